// File: rtl/vga_digit_display_if.sv
// vga_digit_display_if
//   Bundles the pixel stream and the digit/theme control of vga_digit_display.
//   master: sync counter / control side (drives coordinates, load, codes, theme).
//   slave : the renderer (returns pixel, pixel_valid, pending).
//   Signals:
//     h_cnt, v_cnt  current pixel coordinate
//     in_valid      coordinate is in the visible area
//     frame_start   one-cycle pulse per frame, during blanking
//     load          one-cycle request to stage `digits`
//     digits        4-bit code per position, position i at [4i+3:4i]
//     theme         colour theme select
//     blink_mask    bit i set: position i blinks
//     pixel         RGB 4:4:4 result, two cycles after the coordinate
//     pixel_valid   in_valid delayed two cycles
//     pending       a staged value is waiting for frame_start
interface vga_digit_display_if #(
    parameter int DIGITS = 4
);
    logic [9:0]          h_cnt;
    logic [9:0]          v_cnt;
    logic                in_valid;
    logic                frame_start;
    logic                load;
    logic [4*DIGITS-1:0] digits;
    logic [3:0]          theme;
    logic [DIGITS-1:0]   blink_mask;
    logic [11:0]         pixel;
    logic                pixel_valid;
    logic                pending;

    modport master (
        output h_cnt, v_cnt, in_valid, frame_start, load, digits, theme, blink_mask,
        input  pixel, pixel_valid, pending
    );

    modport slave (
        input  h_cnt, v_cnt, in_valid, frame_start, load, digits, theme, blink_mask,
        output pixel, pixel_valid, pending
    );
endinterface

// File: rtl/vga_digit_display.sv
// vga_digit_display
//   Renders a row of DIGITS nine-segment numerals into a 12-bit RGB pixel
//   stream. Coordinates go in, the pixel colour comes out two cycles later.
//   Digit codes and theme are committed only at frame_start so a frame never
//   shows a half-updated value; per-position blinking uses a frame counter.
//   Ports:
//     clk    pixel clock
//     rst_n  asynchronous, active-low reset
//     bus    vga_digit_display_if.slave (pixel stream + control)

// Per-position hit test: is (h,v) inside this cell, and which column/row band.
//   col: 0 = L, 1 = M, 2 = R
//   row: 0 = T, 1 = U, 2 = C, 3 = D, 4 = B
module vga_digit_display_cell #(
    parameter int XS      = 64,
    parameter int Y0      = 48,
    parameter int SEG_LEN = 32,
    parameter int SEG_W   = 6
) (
    input  logic [9:0] h,
    input  logic [9:0] v,
    output logic       hit,
    output logic [1:0] col,
    output logic [2:0] row
);
    localparam int CELL_W = SEG_LEN + 2*SEG_W;
    localparam int CELL_H = 2*SEG_LEN + 3*SEG_W;
    localparam logic [10:0] XL = 11'(XS);
    localparam logic [10:0] XR = 11'(XS + CELL_W);
    localparam logic [10:0] YT = 11'(Y0);
    localparam logic [10:0] YB = 11'(Y0 + CELL_H);
    localparam logic [10:0] B1 = 11'(SEG_W);
    localparam logic [10:0] B2 = 11'(SEG_W + SEG_LEN);
    localparam logic [10:0] B3 = 11'(2*SEG_W + SEG_LEN);
    localparam logic [10:0] B4 = 11'(2*SEG_W + 2*SEG_LEN);

    logic [10:0] hx, vy, lx, ly;

    assign hx  = {1'b0, h};
    assign vy  = {1'b0, v};
    // Range compare on absolute coordinates first; the local offsets below
    // wrap outside the cell but are only consumed when hit is set.
    assign hit = (hx >= XL) && (hx < XR) && (vy >= YT) && (vy < YB);
    assign lx  = hx - XL;
    assign ly  = vy - YT;

    always_comb begin
        col = 2'd2;
        if (lx < B1)      col = 2'd0;
        else if (lx < B2) col = 2'd1;
        row = 3'd4;
        if (ly < B1)      row = 3'd0;
        else if (ly < B2) row = 3'd1;
        else if (ly < B3) row = 3'd2;
        else if (ly < B4) row = 3'd3;
    end
endmodule

module vga_digit_display #(
    parameter int DIGITS       = 4,
    parameter int X0           = 64,
    parameter int Y0           = 48,
    parameter int SEG_LEN      = 32,
    parameter int SEG_W        = 6,
    parameter int GAP          = 8,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    vga_digit_display_if.slave    bus
);
    localparam int PITCH = SEG_LEN + 2*SEG_W + GAP;
    localparam int CW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_FRAMES - 1);
    localparam logic [3:0]    BLANK   = 4'd11;

    // Segment masks per code, bit s = segment s lit.
    function automatic logic [8:0] lit_set(input logic [3:0] code);
        unique case (code)
            4'd0:    lit_set = 9'h1BF;
            4'd1:    lit_set = 9'h106;
            4'd2:    lit_set = 9'h1DB;
            4'd3:    lit_set = 9'h1CF;
            4'd4:    lit_set = 9'h1E6;
            4'd5:    lit_set = 9'h1ED;
            4'd6:    lit_set = 9'h1FD;
            4'd7:    lit_set = 9'h107;
            4'd8:    lit_set = 9'h1FF;
            4'd9:    lit_set = 9'h1E7;
            4'd11:   lit_set = 9'h000;
            default: lit_set = 9'h1C0;   // 10, 12..15: dash
        endcase
    endfunction

    // ---- per-position hit lanes ----
    logic [DIGITS-1:0]      hit;
    logic [DIGITS-1:0][1:0] col;
    logic [DIGITS-1:0][2:0] row;

    for (genvar g = 0; g < DIGITS; g++) begin : g_cell
        vga_digit_display_cell #(
            .XS(X0 + g*PITCH), .Y0(Y0), .SEG_LEN(SEG_LEN), .SEG_W(SEG_W)
        ) u_cell (
            .h(bus.h_cnt), .v(bus.v_cnt), .hit(hit[g]), .col(col[g]), .row(row[g])
        );
    end

    // ---- committed state ----
    logic [DIGITS-1:0][3:0] active_q, staged_q;
    logic                   pending_q;
    logic [3:0]             theme_q;
    logic [DIGITS-1:0]      blink_q;
    logic [CW-1:0]          cnt_q;
    logic                   phase_q;   // 1 = blinking positions shown

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q  <= {DIGITS{BLANK}};
            staged_q  <= '0;
            pending_q <= 1'b0;
            theme_q   <= '0;
            blink_q   <= '0;
            cnt_q     <= '0;
            phase_q   <= 1'b1;
        end else begin
            if (bus.frame_start) begin
                // load in the same cycle bypasses staging and commits at once
                if (bus.load)       active_q <= bus.digits;
                else if (pending_q) active_q <= staged_q;
                if (bus.load)       staged_q <= bus.digits;
                pending_q <= 1'b0;
                theme_q   <= bus.theme;
                blink_q   <= bus.blink_mask;
                if (cnt_q == CNT_MAX) begin
                    cnt_q   <= '0;
                    phase_q <= ~phase_q;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else if (bus.load) begin
                staged_q  <= bus.digits;
                pending_q <= 1'b1;
            end
        end
    end

    assign bus.pending = pending_q;

    // ---- stage 1: select hit lane, resolve code and colours ----
    // The effective code and colours are captured here so a pixel keeps the
    // state that was in force when it entered, even if a commit lands behind it.
    logic        s1_hit_d, s1_hit_q;
    logic [1:0]  s1_col_d, s1_col_q;
    logic [2:0]  s1_row_d, s1_row_q;
    logic [3:0]  s1_code_d, s1_code_q;
    logic [11:0] s1_bg_d, s1_bg_q, s1_fg_d, s1_fg_q;
    logic [2:1]  vld_pipe_q;

    always_comb begin
        s1_hit_d  = 1'b0;
        s1_col_d  = '0;
        s1_row_d  = '0;
        s1_code_d = BLANK;
        for (int i = 0; i < DIGITS; i++) begin
            if (hit[i]) begin
                s1_hit_d  = 1'b1;
                s1_col_d  = col[i];
                s1_row_d  = row[i];
                s1_code_d = (blink_q[i] && !phase_q) ? BLANK : active_q[i];
            end
        end
        unique case (theme_q)
            4'd1:    begin s1_bg_d = 12'hfff; s1_fg_d = 12'h000; end
            4'd2:    begin s1_bg_d = 12'he7d; s1_fg_d = 12'h8f0; end
            default: begin s1_bg_d = 12'h000; s1_fg_d = 12'hfff; end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            s1_hit_q   <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_code_q  <= BLANK;
            s1_bg_q    <= '0;
            s1_fg_q    <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[1], bus.in_valid};
            s1_hit_q   <= s1_hit_d;
            s1_col_q   <= s1_col_d;
            s1_row_q   <= s1_row_d;
            s1_code_q  <= s1_code_d;
            s1_bg_q    <= s1_bg_d;
            s1_fg_q    <= s1_fg_d;
        end
    end

    // ---- stage 2: region -> segment -> colour ----
    logic [3:0]  seg;
    logic        seg_ok, lit;
    logic [8:0]  lset;
    logic [11:0] pixel_d, pixel_q;

    always_comb begin
        seg    = '0;
        seg_ok = 1'b1;
        unique case ({s1_row_q, s1_col_q})
            {3'd0, 2'd1}: seg = 4'd0;
            {3'd1, 2'd2}: seg = 4'd1;
            {3'd3, 2'd2}: seg = 4'd2;
            {3'd4, 2'd1}: seg = 4'd3;
            {3'd3, 2'd0}: seg = 4'd4;
            {3'd1, 2'd0}: seg = 4'd5;
            {3'd2, 2'd1}: seg = 4'd6;
            {3'd2, 2'd0}: seg = 4'd7;
            {3'd2, 2'd2}: seg = 4'd8;
            default:      seg_ok = 1'b0;   // corners, M.U, M.D
        endcase
        lset = lit_set(s1_code_q);
        lit  = seg_ok && lset[seg];
        if (!vld_pipe_q[1])         pixel_d = 12'h000;
        else if (s1_hit_q && lit)   pixel_d = s1_fg_q;
        else                        pixel_d = s1_bg_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pixel_q <= '0;
        else        pixel_q <= pixel_d;
    end

    assign bus.pixel       = pixel_q;
    assign bus.pixel_valid = vld_pipe_q[2];
endmodule

// File: tb/tb_vga_digit_display.sv
module tb_vga_digit_display;
    localparam int DIGITS = 4, X0 = 64, Y0 = 48, SL = 32, SW = 6, GAP = 8, BF = 2;
    localparam int CELL_W = SL + 2*SW, CELL_H = 2*SL + 3*SW, PITCH = CELL_W + GAP;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_chk = 0, n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    vga_digit_display_if #(.DIGITS(DIGITS)) bus ();

    vga_digit_display #(
        .DIGITS(DIGITS), .X0(X0), .Y0(Y0), .SEG_LEN(SL), .SEG_W(SW),
        .GAP(GAP), .BLINK_FRAMES(BF)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        int          due;
        logic [11:0] pix;
        logic        pv;
    } exp_t;
    exp_t q[$];

    // bit c of segmap[s]: code c lights segment s
    logic [15:0] segmap [0:8] = '{16'h03ED, 16'h039F, 16'h03FB, 16'h016D, 16'h0145,
                                  16'h0371, 16'hF77C, 16'hF77D, 16'hF7FF};
    int ox [0:10] = '{22, 41, 41, 22,  3,  3, 22,  3, 41, 22, 3};
    int oy [0:10] = '{ 3, 22, 60, 79, 60, 22, 41, 41, 41, 22, 3};

    // reference state
    logic [15:0] m_active, m_staged;
    logic        m_pending, m_phase;
    logic [3:0]  m_theme, m_mask;
    int          m_cnt;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_active = 16'hBBBB; m_staged = 16'h0; m_pending = 1'b0;
        m_theme = 4'd0; m_mask = 4'd0; m_cnt = 0; m_phase = 1'b1;
    endfunction

    function automatic void model_ctrl(input bit ld, input logic [15:0] d, input bit fs);
        if (fs) begin
            if (ld)             m_active = d;
            else if (m_pending) m_active = m_staged;
            m_pending = 1'b0;
            m_theme   = bus.theme;
            m_mask    = bus.blink_mask;
            if (m_cnt == BF-1) begin m_cnt = 0; m_phase = !m_phase; end
            else m_cnt++;
        end else if (ld) begin
            m_staged  = d;
            m_pending = 1'b1;
        end
    endfunction

    function automatic logic [11:0] model_px(input int x, input int y, input bit vld);
        logic [11:0] bg, fg;
        logic [15:0] codes;
        int xs, lx, ly, code, s;
        bit top, up, mid, dn, bot, lft, rgt, ctr;
        if (!vld) return 12'h000;
        case (m_theme)
            4'd1:    begin bg = 12'hfff; fg = 12'h000; end
            4'd2:    begin bg = 12'he7d; fg = 12'h8f0; end
            default: begin bg = 12'h000; fg = 12'hfff; end
        endcase
        codes = m_active;
        for (int i = 0; i < DIGITS; i++) begin
            xs = X0 + i*PITCH;
            if (x >= xs && x < xs + CELL_W && y >= Y0 && y < Y0 + CELL_H) begin
                lx = x - xs; ly = y - Y0;
                code = (m_mask[i] && !m_phase) ? 11 : int'(codes[4*i +: 4]);
                top = ly < SW;
                up  = ly >= SW && ly < SW + SL;
                mid = ly >= SW + SL && ly < 2*SW + SL;
                dn  = ly >= 2*SW + SL && ly < 2*SW + 2*SL;
                bot = ly >= 2*SW + 2*SL;
                lft = lx < SW;
                rgt = lx >= SW + SL;
                ctr = !lft && !rgt;
                s = -1;
                if (ctr && top) s = 0;
                if (rgt && up)  s = 1;
                if (rgt && dn)  s = 2;
                if (ctr && bot) s = 3;
                if (lft && dn)  s = 4;
                if (lft && up)  s = 5;
                if (ctr && mid) s = 6;
                if (lft && mid) s = 7;
                if (rgt && mid) s = 8;
                if (s >= 0 && segmap[s][code]) return fg;
                return bg;
            end
        end
        return bg;
    endfunction

    task automatic idle();
        bus.in_valid = 1'b0; bus.load = 1'b0; bus.frame_start = 1'b0;
    endtask

    task automatic push(input int x, input int y, input bit v);
        exp_t e;
        e.due = cyc + 2; e.pix = model_px(x, y, v); e.pv = v;
        q.push_back(e);
    endtask

    task automatic drive_xy(input int x, input int y, input bit v);
        bus.h_cnt = 10'(x); bus.v_cnt = 10'(y); bus.in_valid = v;
    endtask

    task automatic px(input int x, input int y, input bit v = 1'b1);
        @(posedge clk); #1;
        idle();
        drive_xy(x, y, v);
        push(x, y, v);
    endtask

    // One control cycle with a probe pixel at (80,50) riding alongside; the
    // probe must see the state from before this cycle's commit.
    task automatic ctrl(input bit ld, input logic [15:0] d, input bit fs);
        @(posedge clk); #1;
        bus.load = ld; bus.digits = d; bus.frame_start = fs;
        drive_xy(80, 50, 1'b1);
        push(80, 50, 1'b1);
        model_ctrl(ld, d, fs);
        @(posedge clk); #1;
        idle();
        chk("pending", {15'd0, bus.pending}, {15'd0, m_pending});
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin @(posedge clk); #1; idle(); end
    endtask

    task automatic sweep();
        for (int i = 0; i < DIGITS; i++)
            for (int k = 0; k < 11; k++)
                px(X0 + i*PITCH + ox[k], Y0 + oy[k]);
    endtask

    // scoreboard: compare each expectation on its due cycle
    always @(negedge clk) begin
        if (q.size() != 0 && q[0].due < cyc) begin
            chk("late", 16'(q[0].due), 16'(cyc));
            void'(q.pop_front());
        end
        if (q.size() != 0 && q[0].due == cyc) begin
            exp_t e;
            e = q.pop_front();
            chk("pixel", {4'd0, bus.pixel}, {4'd0, e.pix});
            chk("pixel_valid", {15'd0, bus.pixel_valid}, {15'd0, e.pv});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        idle();
        bus.h_cnt = '0; bus.v_cnt = '0; bus.digits = '0;
        bus.theme = 4'd0; bus.blink_mask = '0;
        repeat (3) @(negedge clk);
        chk("rst_pixel", {4'd0, bus.pixel}, 16'h0);
        chk("rst_pv", {15'd0, bus.pixel_valid}, 16'h0);
        chk("rst_pending", {15'd0, bus.pending}, 16'h0);
        rst_n = 1'b1;

        // blank digits after reset
        ctrl(1'b0, 16'h0, 1'b1);
        px(70, 50); px(70, 50, 1'b0);

        // staged load, then commit; boundaries around cell 0 and 1
        ctrl(1'b1, 16'h0010, 1'b0);
        px(80, 50); gap(20); px(156, 60);
        ctrl(1'b0, 16'h0, 1'b1);
        px(80, 50); px(80, 88); px(126, 50); px(156, 60); px(66, 48);
        px(63, 50); px(64, 47); px(107, 50); px(108, 60); px(116, 60);
        px(64, 90); px(64, 129); px(70, 130); px(10, 10);

        // overwrite staged value before the commit
        ctrl(1'b1, 16'h9876, 1'b0);
        gap(5); sweep();
        ctrl(1'b1, 16'h5432, 1'b0);
        ctrl(1'b0, 16'h0, 1'b1);
        sweep();

        // load together with frame_start
        ctrl(1'b1, 16'hBA01, 1'b1);
        sweep();

        // blinking on position 0
        bus.blink_mask = 4'b0001;
        ctrl(1'b1, 16'h8888, 1'b1);
        for (int f = 0; f < 6; f++) begin
            ctrl(1'b0, 16'h0, 1'b1);
            px(80, 50); px(132, 50);
        end
        bus.blink_mask = 4'b0000;

        // themes
        bus.theme = 4'd2;
        ctrl(1'b1, 16'h000A, 1'b1);
        px(80, 88); px(80, 50); px(10, 10); px(80, 88, 1'b0);
        bus.theme = 4'd1;
        ctrl(1'b1, 16'h7F3C, 1'b1);
        sweep();
        bus.theme = 4'd0;

        // reset mid-line with a lit pixel streaming
        ctrl(1'b1, 16'h8888, 1'b1);
        repeat (4) px(80, 50);
        @(posedge clk); #1;
        drive_xy(80, 50, 1'b1);
        #2;
        q.delete();
        rst_n = 1'b0;
        #1;
        chk("midrst_pixel", {4'd0, bus.pixel}, 16'h0);
        chk("midrst_pv", {15'd0, bus.pixel_valid}, 16'h0);
        chk("midrst_pending", {15'd0, bus.pending}, 16'h0);
        model_reset();
        idle();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        px(80, 50);
        ctrl(1'b0, 16'h0, 1'b1);
        px(80, 50); px(132, 50);
        ctrl(1'b1, 16'h0008, 1'b1);
        px(80, 50); px(132, 50);

        gap(5);
        chk("drain", 16'(q.size()), 16'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
